// File: rtl/usb_pkg.sv
// Shared encodings for the USB full-speed transmit line stage.
// Holds the state encoding, line symbols and protocol constants.
// Pure declarations, no logic.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX      = 3'd1,
        STUFF   = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } state_t;

    typedef struct packed {
        logic dp;
        logic dm;
    } line_t;

    localparam line_t J   = 2'b10;
    localparam line_t K   = 2'b01;
    localparam line_t SE0 = 2'b00;

    localparam int STUFF_LIMIT  = 6;
    localparam int EOP_SE0_BITS = 2;

    // NRZI: a 0 toggles J<->K, a 1 holds the current symbol.
    function automatic line_t nrzi(input line_t cur, input logic b);
        line_t toggled;
        toggled.dp = ~cur.dp;
        toggled.dm = ~cur.dm;
        return b ? cur : toggled;
    endfunction

endpackage

// File: rtl/usb_bitfifo.sv
// 1-bit wide FIFO buffering the serial bit stream ahead of the line encoder.
// Latency: a pushed bit is visible on rdata/empty the cycle after the push.
// Backpressure: full is registered from the next count; a push while full is dropped.
module usb_bitfifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic wdata,
    output logic rdata,
    output logic empty,
    output logic full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // A push arriving while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    // Occupancy for the coming cycle; full is derived from it so it is registered.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage, pointers and the registered full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/usb_encoder.sv
// USB FS transmit line stage: bit FIFO, NRZI, bit stuffing, EOP; optional USB_ENC_TXCNT_EN adds enc_txbits.
// Latency: first accepted push in cycle N gives dtx_oe=1 and the first line bit in cycle N+2.
// Backpressure: encfifo_full (registered) blocks pushes; writes while full are dropped with no tfifo_rd.
module usb_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic        trsac_encfifo_wr,
    input  logic        trsac_encfifo_wdata,
    input  logic        trsac_tfifoenc_en,
    input  logic        tfifo_rdata,
    output logic        tfifo_rd,
    output logic        encfifo_full,
    output logic        dtx_oe,
    output logic        dtx_dp,
    output logic        dtx_dm
`ifdef USB_ENC_TXCNT_EN
    ,
    output logic [10:0] enc_txbits
`endif
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    state_t        state;
    state_t        state_n;
    line_t         line;
    line_t         line_n;
    logic          oe;
    logic          oe_n;
    logic [2:0]    ones;
    logic [2:0]    ones_n;
    logic [2:0]    ones_base;
    logic [1:0]    se0_cnt;
    logic [1:0]    se0_cnt_n;
    logic [TW-1:0] timer;
    logic          bit_end;

    logic          push;
    logic          push_dat;
    logic          pop;
    logic          fifo_rdata;
    logic          fifo_empty;

    assign push     = trsac_encfifo_wr & ~encfifo_full;
    assign push_dat = trsac_tfifoenc_en ? tfifo_rdata : trsac_encfifo_wdata;
    assign tfifo_rd = push & trsac_tfifoenc_en;

    usb_bitfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_bitfifo (
        .clk   (clk),
        .rst   (rst_async),
        .push  (push),
        .pop   (pop),
        .wdata (push_dat),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (encfifo_full)
    );

    assign bit_end   = (timer == TW'(CLKS_PER_BIT - 1));
    // Run length only carries over from a data bit; after IDLE or a stuff bit it restarts.
    assign ones_base = (state == TX) ? ones : 3'd0;

    assign dtx_oe = oe;
    assign dtx_dp = line.dp;
    assign dtx_dm = line.dm;

    // Bit timer: free-runs through a packet, held at zero while idle.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            timer <= '0;
        end else if (state == IDLE || bit_end) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Next-state, next line symbol, stuffing run length and FIFO pop.
    always_comb begin
        state_n   = state;
        line_n    = line;
        oe_n      = oe;
        ones_n    = ones;
        se0_cnt_n = se0_cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                line_n = J;
                oe_n   = 1'b0;
                ones_n = 3'd0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = TX;
                    oe_n    = 1'b1;
                    line_n  = nrzi(J, fifo_rdata);
                    ones_n  = fifo_rdata ? 3'd1 : 3'd0;
                end
            end
            TX, STUFF: begin
                if (bit_end) begin
                    if (state == TX && ones == 3'(STUFF_LIMIT)) begin
                        state_n = STUFF;
                        line_n  = nrzi(line, 1'b0);
                        ones_n  = 3'd0;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = TX;
                        line_n  = nrzi(line, fifo_rdata);
                        ones_n  = fifo_rdata ? ones_base + 3'd1 : 3'd0;
                    end else begin
                        state_n   = EOP_SE0;
                        line_n    = SE0;
                        ones_n    = 3'd0;
                        se0_cnt_n = 2'd0;
                    end
                end
            end
            EOP_SE0: begin
                if (bit_end) begin
                    if (se0_cnt == 2'(EOP_SE0_BITS - 1)) begin
                        state_n = EOP_J;
                        line_n  = J;
                    end else begin
                        se0_cnt_n = se0_cnt + 2'd1;
                    end
                end
            end
            EOP_J: begin
                if (bit_end) begin
                    state_n = IDLE;
                    line_n  = J;
                    oe_n    = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                line_n  = J;
                oe_n    = 1'b0;
                ones_n  = 3'd0;
            end
        endcase
    end

    // State, line and output-enable registers; reset aborts a packet without EOP.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state   <= IDLE;
            line    <= J;
            oe      <= 1'b0;
            ones    <= 3'd0;
            se0_cnt <= 2'd0;
        end else begin
            state   <= state_n;
            line    <= line_n;
            oe      <= oe_n;
            ones    <= ones_n;
            se0_cnt <= se0_cnt_n;
        end
    end

`ifdef USB_ENC_TXCNT_EN
    logic [10:0] txcnt;
    logic        bit_done;

    assign bit_done = (state == TX || state == STUFF) && bit_end;

    // Line-bit count of the current packet, published when the EOP starts.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            txcnt      <= '0;
            enc_txbits <= '0;
        end else begin
            if (state == IDLE && state_n == TX) begin
                txcnt <= '0;
            end else if (bit_done) begin
                txcnt <= txcnt + 11'd1;
            end
            if (bit_done && state_n == EOP_SE0) begin
                enc_txbits <= txcnt + 11'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_encoder.sv
// Directed bench for usb_encoder: ACK, stuffing, back-pressure, TFIFO path, reset abort.
// Line activity is captured on the falling edge and compared with hand-computed symbols.
// Inputs change on the falling edge; full is sampled there before deciding a push was taken.
module tb_usb_encoder;

    logic clk;
    logic rst_async;
    logic wr;
    logic wdata;
    logic en;
    logic tf_rdata;
    logic tf_rd;
    logic full;
    logic oe;
    logic dp;
    logic dm;
`ifdef USB_ENC_TXCNT_EN
    logic [10:0] enc_txbits;
`endif

    usb_encoder #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk                 (clk),
        .rst_async           (rst_async),
        .trsac_encfifo_wr    (wr),
        .trsac_encfifo_wdata (wdata),
        .trsac_tfifoenc_en   (en),
        .tfifo_rdata         (tf_rdata),
        .tfifo_rd            (tf_rd),
        .encfifo_full        (full),
        .dtx_oe              (oe),
        .dtx_dp              (dp),
        .dtx_dm              (dm)
`ifdef USB_ENC_TXCNT_EN
        ,
        .enc_txbits          (enc_txbits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [1:0] trace[$];
    int  oe_rises = 0;
    int  oe_rise_cyc = -1;
    int  full_rises = 0;
    int  idle_bad = 0;
    int  rd_pulses = 0;
    int  rd_full = 0;
    int  first_push_cyc = -1;
    logic oe_prev = 1'b0;
    logic full_prev = 1'b0;
    logic timed_out;

    always @(posedge clk) cyc <= cyc + 1;

    // Line recorder: every cycle with oe high contributes one {dp,dm} sample.
    always @(negedge clk) begin
        if (oe === 1'b1) begin
            trace.push_back({dp, dm});
            if (!oe_prev) begin
                oe_rises++;
                oe_rise_cyc = cyc;
            end
        end else if (dp !== 1'b1 || dm !== 1'b0) begin
            idle_bad++;
        end
        oe_prev = oe;
        if (full && !full_prev) full_rises++;
        full_prev = full;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Push n bits (index 0 first), holding wr high through back-pressure.
    task automatic feed(input logic [63:0] bits, input int n, input logic use_tf);
        int   i;
        int   guard;
        logic acc;
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            wr = 1'b1;
            en = use_tf;
            tf_rdata = use_tf ? bits[i] : ~bits[i];
            wdata    = use_tf ? ~bits[i] : bits[i];
            #1;
            acc = !full;
            if (tf_rd) begin
                rd_pulses++;
                if (full) rd_full++;
            end
            if (acc && first_push_cyc < 0) first_push_cyc = cyc;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        @(negedge clk);
        wr = 1'b0;
        en = 1'b0;
        chk("feed_timeout", 64'(i < n), 64'd0);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!(trace.size() > 0 && oe === 1'b0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        timed_out = (g >= 3000);
        chk("pkt_timeout", 64'(timed_out), 64'd0);
    endtask

    // Compare captured line: length, data-bit symbols (dp at bit centre), stability, EOP.
    task automatic check_pkt(input string tag, input int nbits, input logic [63:0] exp_dp);
        logic [63:0] got;
        logic        stable;
        logic        eop_ok;
        int          idx;
        got = '0;
        stable = 1'b1;
        eop_ok = 1'b1;
        chk({tag, "_oe_cycles"}, 64'(trace.size()), 64'(nbits * 4 + 12));
        for (int k = 0; k < nbits; k++) begin
            idx = 4 * k + 2;
            if (idx < trace.size()) got[nbits-1-k] = trace[idx][1];
            else got[nbits-1-k] = 1'bx;
            for (int s = 0; s < 4; s++) begin
                if (4 * k + s >= trace.size() || idx >= trace.size()) stable = 1'b0;
                else if (trace[4*k+s] !== trace[idx] || (trace[idx] !== 2'b10 && trace[idx] !== 2'b01))
                    stable = 1'b0;
            end
        end
        for (int j = 0; j < 12; j++) begin
            idx = nbits * 4 + j;
            if (idx >= trace.size()) eop_ok = 1'b0;
            else if (trace[idx] !== ((j < 8) ? 2'b00 : 2'b10)) eop_ok = 1'b0;
        end
        chk({tag, "_bits"}, got, exp_dp);
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        chk({tag, "_eop"}, 64'(eop_ok), 64'd1);
        chk({tag, "_one_pkt"}, 64'(oe_rises), 64'd1);
    endtask

    task automatic start_test();
        @(negedge clk);
        trace.delete();
        oe_rises = 0;
        full_rises = 0;
        rd_pulses = 0;
        rd_full = 0;
        first_push_cyc = -1;
        oe_rise_cyc = -1;
    endtask

    initial begin
        wr = 1'b0;
        wdata = 1'b0;
        en = 1'b0;
        tf_rdata = 1'b0;
        rst_async = 1'b1;
        #12;
        chk("rst_oe", 64'(oe), 64'd0);
        chk("rst_line", 64'({dp, dm}), 64'b10);
        chk("rst_full", 64'(full), 64'd0);
        @(negedge clk);
        rst_async = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_oe", 64'(oe), 64'd0);
        chk("idle_tfrd", 64'(tf_rd), 64'd0);

        // ACK: sync 0x80 then PID 0xD2, LSB first.
        start_test();
        feed({48'd0, 8'hD2, 8'h80}, 16, 1'b0);
        wait_done();
        check_pkt("ack", 16, 64'b0101010011011000);
        chk("ack_latency", 64'(oe_rise_cyc - first_push_cyc), 64'd2);
        chk("ack_no_tfrd", 64'(rd_pulses), 64'd0);
`ifdef USB_ENC_TXCNT_EN
        chk("ack_txbits", 64'(enc_txbits), 64'd16);
`endif

        // Stuff bit after the sixth consecutive 1 (sync MSB plus five of 0xFF).
        start_test();
        feed({48'd0, 8'hFF, 8'h80}, 16, 1'b0);
        wait_done();
        check_pkt("stuff_mid", 17, 64'b01010100000001111);
`ifdef USB_ENC_TXCNT_EN
        chk("stuff_mid_txbits", 64'(enc_txbits), 64'd17);
`endif

        // Packet ending with six 1s still gets its stuff bit before EOP.
        start_test();
        feed({57'd0, 7'b1111110}, 7, 1'b0);
        wait_done();
        check_pkt("stuff_end", 8, 64'b00000001);

        // 40 bits with wr held high: full toggles, no loss, no gap.
        start_test();
        feed({24'd0, 40'hCCCCCCCCCC}, 40, 1'b0);
        wait_done();
        check_pkt("bp", 40, 64'h7777777777);
        chk("bp_full_toggles", 64'(full_rises > 1), 64'd1);

        // TFIFO source: 1,0,1,1 twice; wdata carries the inverse.
        start_test();
        feed({56'd0, 8'hDD}, 8, 1'b1);
        wait_done();
        check_pkt("tf", 8, 64'b10000111);
        chk("tf_rd_pulses", 64'(rd_pulses), 64'd8);
        chk("tf_rd_while_full", 64'(rd_full), 64'd0);
        chk("tf_full_seen", 64'(full_rises > 0), 64'd1);

        // Reset in the middle of a run of 1s; no EOP, FIFO flushed, run length cleared.
        start_test();
        feed({56'd0, 8'hFF}, 8, 1'b0);
        repeat (6) @(posedge clk);
        #3;
        rst_async = 1'b1;
        #1;
        chk("abort_oe", 64'(oe), 64'd0);
        chk("abort_line", 64'({dp, dm}), 64'b10);
        chk("abort_full", 64'(full), 64'd0);
        @(negedge clk);
        rst_async = 1'b0;
        trace.delete();
        repeat (20) @(negedge clk);
        chk("abort_fifo_empty", 64'(trace.size()), 64'd0);
        start_test();
        feed({57'd0, 7'b0111111}, 7, 1'b0);
        wait_done();
        check_pkt("fresh", 8, 64'b11111101);

        chk("idle_line_j", 64'(idle_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_encoder.md
Name: usb_encoder

Overview:
- Transmit line stage directly downstream of the transaction controller.
- Accepts a serial bit stream through a small bit FIFO, from either the controller's wdata or the TFIFO data bit.
- Applies NRZI encoding and bit stuffing, appends EOP, and drives the full-speed differential transmit pins plus the output enable.
- Exports encfifo_full and dtx_oe back to the controller for back-pressure and handshake timeout counting.

Parameters:
CLKS_PER_BIT, 4, clk cycles per USB bit time (48 MHz clk -> 12 Mb/s)
FIFO_DEPTH, 4, bit FIFO depth in bits (power of two, >=2)

Ports:
clk  in  1  system clock
rst_async  in  1  reset; asynchronous, active-high
trsac_encfifo_wr  in  1  write request from transaction controller
trsac_encfifo_wdata  in  1  bit from controller (used when tfifoenc_en=0)
trsac_tfifoenc_en  in  1  1: source bit is tfifo_rdata
tfifo_rdata  in  1  payload bit from TFIFO
tfifo_rd  out  1  TFIFO pop, combinational
encfifo_full  out  1  bit FIFO full, registered
dtx_oe  out  1  transceiver output enable, registered
dtx_dp  out  1  D+ drive, registered
dtx_dm  out  1  D- drive, registered

Behaviour:
- Reset (async, active-high):
  - FIFO empty; encfifo_full=0; dtx_oe=0; dtx_dp=1, dtx_dm=0 (J); state IDLE.
  - Reset mid-packet aborts immediately; no EOP is sent.
- Push:
  - push = trsac_encfifo_wr & !encfifo_full.
  - Data = trsac_tfifoenc_en ? tfifo_rdata : trsac_encfifo_wdata.
  - tfifo_rd = push & trsac_tfifoenc_en.
  - A write while full is dropped and produces no tfifo_rd.
- Full/pop rules:
  - encfifo_full = (count==FIFO_DEPTH), updated each cycle from the next count.
  - Push and pop in the same cycle leave count unchanged; pop with push-while-full performs the pop only.
- Bit timer: counts 0..CLKS_PER_BIT-1 while not IDLE; "bit end" = timer==CLKS_PER_BIT-1.
- States:
  - IDLE: dtx_oe=0, line J, ones=0. If FIFO non-empty: pop, go TX.
    - Next cycle: dtx_oe=1 and line = NRZI(bit) from J.
    - Latency: first accepted push at cycle N -> dtx_oe=1 at N+2.
  - TX:
    - NRZI: bit 0 toggles J<->K; bit 1 holds the line.
    - ones increments on 1 and clears on 0.
    - At bit end, in priority order:
      - ones==6: go STUFF;
      - else FIFO non-empty: pop next bit, stay TX;
      - else go EOP_SE0.
  - STUFF: one bit time of inserted 0 (line toggles), ones=0. At bit end: FIFO non-empty -> pop, TX; else EOP_SE0.
    - A stuff bit is always inserted after six 1s, including as the final data bits.
  - EOP_SE0: dp=dm=0 for 2 bit times -> EOP_J.
  - EOP_J: J for 1 bit time -> IDLE; dtx_oe=0 the cycle after.
- Pushes accepted during EOP are held and start the next packet from IDLE. There is always at least one IDLE cycle between packets.
- Packet boundary is defined solely by FIFO empty at bit end. The controller must sustain writes; with depth 4 and 4 clk/bit, a one-cycle write gap is tolerated.
- Line constants: J={dp=1,dm=0}, K={0,1}, SE0={0,0}. K and SE0 only ever appear while dtx_oe=1.

Optional Feature:
- USB_ENC_TXCNT_EN defined:
  - Adds output enc_txbits[10:0] (line bits of the last packet, including stuff bits and excluding EOP).
  - Internal counter clears on IDLE->TX and increments at each TX/STUFF bit end.
  - enc_txbits is updated on entry to EOP_SE0 and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package usb_pkg holds:
  - state encoding (IDLE, TX, STUFF, EOP_SE0, EOP_J);
  - line constants J, K, SE0;
  - STUFF_LIMIT=6 and EOP_SE0_BITS=2.
- One sub-module: usb_bitfifo (1-bit wide, FIFO_DEPTH deep, registered full, push/pop/empty/rdata).
- NRZI, stuffing and the FSM stay in usb_encoder.

Test Plan:
- ACK handshake: push 16 bits (sync 0x80 then PID 0xD2, LSB first) continuously -> K,J,K,J,K,J,K,K then PID NRZI, SE0 8 clk, J 4 clk; dtx_oe high exactly 76 clk.
- Stuffing mid-packet: sync then 0xFF -> stuff 0 inserted after 6th 1; 17 data-line bits before EOP.
- Stuffing at end: packet ending with six 1s -> stuff bit emitted, then SE0, SE0, J.
- Back-pressure: trsac_encfifo_wr held high for 40 bits -> encfifo_full toggles, no bit lost or duplicated, no gap on line, single EOP.
- TFIFO path: trsac_tfifoenc_en=1, tfifo_rdata=1,0,1,1 -> one tfifo_rd pulse per accepted push, none while full; line carries tfifo bits.
- Reset mid-packet at bit 5: dp=1, dm=0, dtx_oe=0 asynchronously; FIFO empty; next push starts a fresh packet with ones=0.
